// File: rtl/upc_scanner.sv
// Serial front end for the UPC item checker: oversampled 7-bit frames
// (start, u, p, c, m, even parity, stop) decoded into held item-code outputs.
module upc_scanner #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic serial_in,
  output logic u,
  output logic p,
  output logic c,
  output logic m,
  output logic valid,
  output logic par_err,
  output logic frame_err,
  output logic busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cyc;
  logic [1:0]    bitcnt;
  logic [3:0]    shadow;
  logic          par_bit;
  logic          sync1, sync2;
  logic          rx;

  // The line is asynchronous; reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
    end
  end

  assign rx   = sync2;
  assign busy = (state != IDLE);

  // Each bit is sampled once near its centre; nothing between samples matters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cyc       <= '0;
      bitcnt    <= 2'd0;
      shadow    <= 4'd0;
      par_bit   <= 1'b0;
      u         <= 1'b0;
      p         <= 1'b0;
      c         <= 1'b0;
      m         <= 1'b0;
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      par_err   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx) begin
            state <= START;
            cyc   <= '0;
          end
        end
        START: begin
          if (cyc == HALF_LAST) begin
            cyc <= '0;
            if (rx) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              bitcnt <= 2'd0;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DATA: begin
          if (cyc == BIT_LAST) begin
            cyc    <= '0;
            shadow <= {shadow[2:0], rx};
            if (bitcnt == 2'd3) begin
              state <= PARITY;
            end else begin
              bitcnt <= bitcnt + 2'd1;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        PARITY: begin
          if (cyc == BIT_LAST) begin
            cyc     <= '0;
            par_bit <= rx;
            state   <= STOP;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        STOP: begin
          if (cyc == BIT_LAST) begin
            cyc <= '0;
            if (rx) begin
              state <= IDLE;
              if (^{shadow, par_bit} == 1'b0) begin
                {u, p, c, m} <= shadow;
                valid        <= 1'b1;
              end else begin
                par_err <= 1'b1;
              end
            end else begin
              // A low stop bit means the line may be stuck low; wait for it to recover.
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upc_scanner.sv
// Directed bench for upc_scanner: frames are queued as expected strobes when
// driven and matched against DUT strobes (kind, cycle, code) by a monitor.
module tb_upc_scanner;

  localparam int CPB = 4;
  localparam int STROBE_LAT = 3 + CPB / 2 + 6 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic serial_in;
  logic u, p, c, m;
  logic valid, par_err, frame_err, busy;

  typedef struct {
    logic [2:0] kind;
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cycle = 0;
  int         checks = 0;
  int         fails = 0;
  logic [3:0] model_code = 4'd0;
  logic [3:0] shown = 4'd0;
  logic       rst_q = 1'b0;
  logic       busy_q = 1'b0;
  int         last_rise = -1;
  int         last_fall = -1;
  int         n0, n1;

  upc_scanner #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .serial_in(serial_in),
    .u(u),
    .p(p),
    .c(c),
    .m(m),
    .valid(valid),
    .par_err(par_err),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    rst_q <= reset;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic driveBit(input logic b);
    serial_in = b;
    repeat (CPB) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // code is {u,p,c,m}; the expected outcome is derived from parity and stop.
  task automatic applyStimulus(input logic [3:0] code, input logic par, input logic stop);
    exp_t       e;
    logic [6:0] bits;
    e.cyc = cycle + STROBE_LAT;
    if (!stop) begin
      e.kind = 3'b001;
      e.code = model_code;
    end else if (^{code, par}) begin
      e.kind = 3'b010;
      e.code = model_code;
    end else begin
      e.kind     = 3'b100;
      e.code     = code;
      model_code = code;
    end
    sb.push_back(e);
    bits = {1'b0, code[3], code[2], code[1], code[0], par, stop};
    for (int i = 6; i >= 0; i--) driveBit(bits[i]);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (cycle > 0) begin
      if (rst_q) shown = 4'd0;
      if (busy && !busy_q) last_rise = cycle;
      if (!busy && busy_q) last_fall = cycle;
      busy_q = busy;
      if (valid || par_err || frame_err) begin
        checkOutput("strobe_onehot", 32'(valid) + 32'(par_err) + 32'(frame_err), 32'd1);
        if (sb.size() == 0) begin
          checkOutput("unexpected_strobe", 32'({valid, par_err, frame_err}), 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("strobe_kind", 32'({valid, par_err, frame_err}), 32'(e.kind));
          checkOutput("strobe_cycle", 32'(cycle), 32'(e.cyc));
          checkOutput("strobe_code", 32'({u, p, c, m}), 32'(e.code));
          if (e.kind == 3'b100) shown = e.code;
        end
      end else begin
        checkOutput("held_code", 32'({u, p, c, m}), 32'(shown));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", 32'({u, p, c, m, valid, par_err, frame_err, busy}), 32'd0);
    reset = 1'b0;
    idle(4);

    $display("[TB] good frame 1010");
    n0 = cycle;
    applyStimulus(4'b1010, 1'b0, 1'b1);
    idle(4);
    checkOutput("good_busy_rise", 32'(last_rise), 32'(n0 + 3));
    checkOutput("good_busy_fall", 32'(last_fall), 32'(n0 + STROBE_LAT));
    checkOutput("good_code", 32'({u, p, c, m}), 32'h0000000a);

    $display("[TB] bad parity 1110");
    applyStimulus(4'b1110, 1'b0, 1'b1);
    idle(4);
    checkOutput("parity_code_held", 32'({u, p, c, m}), 32'h0000000a);

    $display("[TB] one-cycle glitch");
    n0 = cycle;
    serial_in = 1'b0;
    @(posedge clk);
    #1;
    idle(8);
    checkOutput("glitch_busy_rise", 32'(last_rise), 32'(n0 + 3));
    checkOutput("glitch_busy_fall", 32'(last_fall), 32'(n0 + 3 + CPB / 2));

    $display("[TB] framing error with held-low line");
    n0 = cycle;
    applyStimulus(4'b0110, 1'b0, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("wait_idle_busy", 32'(busy), 32'd1);
    checkOutput("frame_busy_rise", 32'(last_rise), 32'(n0 + 3));
    n1 = cycle;
    idle(6);
    checkOutput("wait_idle_exit", 32'(last_fall), 32'(n1 + 3));
    checkOutput("frame_code_held", 32'({u, p, c, m}), 32'h0000000a);

    $display("[TB] back-to-back frames");
    applyStimulus(4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b0110, 1'b0, 1'b1);
    idle(4);
    checkOutput("b2b_code", 32'({u, p, c, m}), 32'h00000006);

    $display("[TB] reset during data bit c");
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b1);
    serial_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset     = 1'b1;
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_code = 4'd0;
    checkOutput("midframe_reset", 32'({u, p, c, m, valid, par_err, frame_err, busy}), 32'd0);
    idle(8);
    applyStimulus(4'b1100, 1'b0, 1'b1);
    idle(6);
    checkOutput("post_reset_code", 32'({u, p, c, m}), 32'h0000000c);
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/upc_scanner.md
# upc_scanner

Serial front end for the UPC item checker. Receives framed 4-bit item codes from the scanner line, oversamples each bit, checks even parity and the stop bit, and presents the decoded code as the held outputs `u`, `p`, `c`, `m` to the combinational stolen/discount logic. A one-cycle `valid` strobe marks each new code; corrupted frames raise error strobes and leave the held code unchanged.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; minimum 2. `HALF = CLKS_PER_BIT/2` (integer division).
- `clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `serial_in`  in  1  scanner line; idles high
- `u`, `p`, `c`, `m`  out  1 each  last good item code; held until the next good frame
- `valid`  out  1  one-cycle pulse: `u`/`p`/`c`/`m` were just updated
- `par_err`  out  1  one-cycle pulse: frame had a good stop bit but bad parity
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `busy`  out  1  high whenever the state is not IDLE

## Operation
- Frame, 7 bits, in order: start (0), u, p, c, m, parity, stop (1). Parity is even: u^p^c^m^parity == 0.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. A bit counter (0..3) indexes DATA. A cycle counter runs 0..CLKS_PER_BIT-1.
- IDLE: when `serial_in`==0 at an edge, go to START and clear the cycle counter. This edge is t0.
- START: at t0+HALF, sample the line. If it is 1, treat the frame as a glitch: return to IDLE with no strobe. If it is 0, go to DATA.
- Bit i (1..4 data, 5 parity, 6 stop) is sampled at edge t0+HALF+i·CLKS_PER_BIT. Data bits shift into a 4-bit shadow register, u first.
- STOP sample:
  - stop=1 and parity good: load the shadow register into u/p/c/m, pulse `valid`, go to IDLE.
  - stop=1 and parity bad: pulse `par_err`, leave outputs unchanged, go to IDLE.
  - stop=0: pulse `frame_err`, leave outputs unchanged, go to WAIT_IDLE. Parity is not reported.
- WAIT_IDLE: stay until `serial_in`==1 at an edge, then go to IDLE. This prevents a held-low line from being decoded as back-to-back frames.
- Line transitions between sample points are ignored. There is no resynchronisation mid-frame.

## Timing
- Reset values: state IDLE, all counters 0, shadow 0. Outputs: `u`=`p`=`c`=`m`=0, `valid`=`par_err`=`frame_err`=0, `busy`=0.
- Reset takes priority over every event, including reset asserted mid-frame or on the stop-sample edge. In that case no strobe is produced and the partial frame is discarded.
- Strobes and output updates are registered on the stop-sample edge t0+HALF+6·CLKS_PER_BIT. They are visible for exactly the following cycle.
- At most one of `valid`, `par_err`, `frame_err` is high in any cycle.
- `busy` rises in the cycle after t0 and falls in the cycle after the stop-sample edge. For a frame_err it falls only after WAIT_IDLE exits.
- Back-to-back frames: IDLE may detect a new start bit on the edge immediately after the stop-sample edge. There is no dead cycle.
- `serial_in` is an asynchronous source. `serial_in` passes through a 2-flop synchronizer, reset high, before all logic. All edge numbers above count from the synchronized signal, which adds 2 cycles of fixed latency from the pin.

## Test plan
All scenarios use CLKS_PER_BIT=4, so HALF=2; t0 refers to the synchronized line.
- Good frame, code u,p,c,m = 1,0,1,0, parity 0, stop 1 -> at t0+26, `valid` pulses for 1 cycle with u=1,p=0,c=1,m=0. `busy` is high from t0+1 to t0+26.
- Bad parity: code 1,1,1,0 with parity 0 -> `par_err` pulses at t0+26. `valid` stays 0 and outputs keep the previous code 1,0,1,0.
- Glitch: line low for 1 cycle only, starting at t0 -> START samples 1 at t0+2, returns to IDLE, no strobe, outputs unchanged.
- Framing error: stop bit 0 and line held low for 10 more cycles -> `frame_err` pulses at t0+26. State stays WAIT_IDLE and `busy`=1 until the line returns high, then IDLE. The held-low period decodes no frame.
- Back-to-back frames: code 0,0,0,1 (parity 1) immediately followed by code 0,1,1,0 (parity 0), with no idle gap -> two `valid` pulses exactly 28 cycles apart; the outputs read 0,0,0,1 then 0,1,1,0.
- Reset mid-frame: assert `reset` for 1 cycle during DATA bit c -> all outputs 0 next cycle and `busy`=0. A following good frame with code 1,1,0,0 then decodes normally with `valid`.
